run_led_sched: RTL and testbench
================================

# run_led_sched

Sequencer for the 4-LED run-light board. It drives LED_Out[3:0] from a step timer (default 1 s per step at the 50 MHz board clock) and steps through one of four patterns: chase-left, chase-right, ping-pong or blink-all. Start, Stop and Hold requests come from the key/debounce logic upstream. It replaces the per-LED fixed-window blink modules with one scheduler that owns all four LEDs.

## Interface
- T_STEP, 28'd50_000_000: clock cycles per pattern step; must be ≥ 2; benches override it with a small value.
- CLK  in  1  board clock, 50 MHz, rising edge.
- RSTn  in  1  asynchronous active-low reset.
- Start  in  1  synchronous single-cycle request to start or restart the sequence.
- Stop  in  1  synchronous request to stop the sequence and blank the LEDs.
- Hold  in  1  level; freezes the sequence while high.
- Mode_Sel  in  2  pattern select: 0 chase-left, 1 chase-right, 2 ping-pong, 3 blink-all.
- LED_Out  out  4  registered LED drive, 1 = lit.
- Busy  out  1  registered; high in RUN or PAUSE.
- Step_Done  out  1  registered one-cycle pulse on each step advance.

## Operation
- States:
  - IDLE
  - RUN
  - PAUSE
- Internal registers:
  - Count[27:0], the step timer
  - rMode[1:0], the latched mode
  - Dir, the ping-pong direction: 0 = moving toward bit 3
- Initial pattern by mode:
  - Mode 0: 0001
  - Mode 1: 1000
  - Mode 2: 0001, with Dir = 0
  - Mode 3: 1111
- Next pattern by mode:
  - Mode 0: rotate left, 1000 → 0001.
  - Mode 1: rotate right, 0001 → 1000.
  - Mode 2: shift toward bit 3 while Dir = 0. On reaching 1000, set Dir = 1 and shift toward bit 0 on later steps. On reaching 0001, set Dir = 0. Six-step cycle: 0001, 0010, 0100, 1000, 0100, 0010, then repeat.
  - Mode 3: invert (1111 ↔ 0000).
- Transitions, evaluated in priority order each edge:
  - Stop (any state) → IDLE. Clear Count, LED_Out and Dir. Stop has priority over Start when both are high in the same cycle.
  - Start (any state, no Stop) → RUN.
    - Clear Count.
    - Latch rMode = Mode_Sel.
    - Load the initial pattern of Mode_Sel.
    - In RUN or PAUSE this restarts the sequence; Hold is ignored on that edge.
  - RUN with Hold = 1 → PAUSE. Count and LED_Out freeze.
  - PAUSE with Hold = 0 → RUN. Count resumes from the frozen value, with no extra step and no lost cycles.
  - RUN timing:
    - While Count < T_STEP−1, increment Count.
    - When Count = T_STEP−1, step boundary: Count ← 0 and Step_Done ← 1.
    - At the boundary, if Mode_Sel ≠ rMode, latch the new mode and load its initial pattern.
    - Otherwise load the next pattern of rMode.
- Mode_Sel is sampled only at Start and at step boundaries. Changes mid-step have no effect until the boundary.
- Count is 28 bits unsigned and never exceeds T_STEP−1. There is no wrap-around beyond the compare.
- IDLE: LED_Out = 0000, Busy = 0. Start is the only way out.

## Timing
- Reset values:
  - state = IDLE
  - LED_Out = 4'b0000
  - Busy = 0
  - Step_Done = 0
  - Count = 0
  - rMode = 0
  - Dir = 0
- Reset is asynchronous, and assertion mid-sequence blanks the LEDs immediately.
- Start latency:
  - Start is high in cycle N.
  - From cycle N+1: LED_Out = initial pattern and Busy = 1.
  - The first step advance appears in cycle N+1+T_STEP.
- Each step holds LED_Out for exactly T_STEP cycles in RUN, plus any cycles spent in PAUSE.
- Step_Done is high in the first cycle of each new pattern, for exactly one cycle. It is never asserted in IDLE or PAUSE, or by Start.
- Stop latency: Stop is high in cycle N; from cycle N+1, LED_Out = 0000 and Busy = 0.
- Hold latency: Hold rises in cycle N; Count is frozen from cycle N+1.
  - If cycle N was a boundary cycle (Count = T_STEP−1), Hold wins: no advance, and the step completes one cycle after release.

## Test plan
- **Reset, chase-left:** T_STEP = 4, Mode_Sel = 0, Start pulse.
  - Required: LED_Out = 0001, then 0010, 0100, 1000, 0001, each held exactly 4 cycles.
  - Required: Step_Done pulses every 4 cycles.
  - Required: async RSTn low mid-step forces 0000 without waiting for a clock edge.
- **Ping-pong:** Mode_Sel = 2, T_STEP = 3.
  - Required: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, with Dir flipping at 1000 and at 0001.
- **Mode change mid-step:** in mode 0 at LED 0100, set Mode_Sel = 3 at Count = 1.
  - Required: 0100 held for the full T_STEP, then 1111, then 0000, 1111.
- **Hold:** in RUN with T_STEP = 4, raise Hold at Count = 2 for 10 cycles.
  - Required: LED_Out unchanged.
  - Required: Busy = 1 and no Step_Done while held.
  - Required: the advance occurs 2 cycles after Hold falls.
- **Simultaneous Start and Stop in RUN:** assert both in the same cycle.
  - Required: next cycle IDLE, LED_Out = 0000, Busy = 0.
  - Required: a later Start alone restarts at the initial pattern with Count = 0.
- **Restart in RUN:** at mode 1, LED 0010, pulse Start with Mode_Sel = 0.
  - Required: next cycle LED_Out = 0001, no Step_Done pulse.
  - Required: the next advance comes after exactly T_STEP cycles.

Source files
------------

// File: rtl/run_led_sched.sv
// run_led_sched: four-LED run-light sequencer with step timer, hold/pause and four selectable patterns.
module run_led_sched #(
   parameter logic [27:0] T_STEP = 28'd50_000_000
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic       Start,
   input  logic       Stop,
   input  logic       Hold,
   input  logic [1:0] Mode_Sel,
   output logic [3:0] LED_Out,
   output logic       Busy,
   output logic       Step_Done
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
   state_t      state, state_n;
   logic [27:0] count, count_n;
   logic [1:0]  r_mode, mode_n;
   logic        dir, dir_n, done_n;
   logic [3:0]  led_n, step_led, pp_led;

   function automatic logic [3:0] init_pat(input logic [1:0] m);
      return m == 2'd3 ? 4'b1111 : m == 2'd1 ? 4'b1000 : 4'b0001;
   endfunction

   always_comb begin
      pp_led   = dir ? LED_Out >> 1 : LED_Out << 1;
      step_led = r_mode == 2'd0 ? {LED_Out[2:0], LED_Out[3]} :
                 r_mode == 2'd1 ? {LED_Out[0], LED_Out[3:1]} :
                 r_mode == 2'd2 ? pp_led : ~LED_Out;
      state_n  = state;
      count_n  = count;
      mode_n   = r_mode;
      dir_n    = dir;
      led_n    = LED_Out;
      done_n   = 1'b0;
      if (Stop) begin
         state_n = IDLE;
         count_n = '0;
         led_n   = '0;
         dir_n   = 1'b0;
      end else if (Start) begin
         state_n = RUN;
         count_n = '0;
         mode_n  = Mode_Sel;
         led_n   = init_pat(Mode_Sel);
         dir_n   = 1'b0;
      end else if (state != IDLE) begin
         // a PAUSE cycle with Hold released already counts, so no cycle is lost on resume
         state_n = Hold ? PAUSE : RUN;
         if (!Hold && count == T_STEP - 28'd1) begin
            count_n = '0;
            done_n  = 1'b1;
            if (Mode_Sel != r_mode) begin
               mode_n = Mode_Sel;
               led_n  = init_pat(Mode_Sel);
               dir_n  = 1'b0;
            end else begin
               led_n = step_led;
               dir_n = r_mode != 2'd2 ? dir : pp_led == 4'b1000 ? 1'b1 : pp_led == 4'b0001 ? 1'b0 : dir;
            end
         end else if (!Hold) begin
            count_n = count + 28'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state     <= IDLE;
         count     <= '0;
         r_mode    <= '0;
         dir       <= 1'b0;
         LED_Out   <= '0;
         Busy      <= 1'b0;
         Step_Done <= 1'b0;
      end else begin
         state     <= state_n;
         count     <= count_n;
         r_mode    <= mode_n;
         dir       <= dir_n;
         LED_Out   <= led_n;
         Busy      <= state_n != IDLE;
         Step_Done <= done_n;
      end
   end
endmodule

// File: tb/tb_run_led_sched.sv
// tb_run_led_sched: directed checks of patterns, hold, stop/start priority and restart on two step lengths.
module tb_run_led_sched;
   logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0, hold = 1'b0;
   logic [1:0] mode_sel = 2'd0;
   logic [3:0] led4, led3;
   logic       busy4, busy3, done4, done3;
   int         n_vec = 0, n_err = 0;

   run_led_sched #(.T_STEP(28'd4)) dut4 (.CLK(clk), .RSTn(rst_n), .Start(start), .Stop(stop), .Hold(hold),
      .Mode_Sel(mode_sel), .LED_Out(led4), .Busy(busy4), .Step_Done(done4));
   run_led_sched #(.T_STEP(28'd3)) dut3 (.CLK(clk), .RSTn(rst_n), .Start(start), .Stop(stop), .Hold(hold),
      .Mode_Sel(mode_sel), .LED_Out(led3), .Busy(busy3), .Step_Done(done3));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [1:0] m);
      mode_sel = m;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      n_vec++;
      if (led4 !== 4'b0000 || busy4 !== 1'b0 || done4 !== 1'b0)
         $display("FAIL reset: got led=%b busy=%b done=%b want led=0000 busy=0 done=0", led4, busy4, done4);
      if (led4 !== 4'b0000 || busy4 !== 1'b0 || done4 !== 1'b0) n_err++;
      rst_n = 1'b1;
      tick();
      n_vec++;
      if (led4 !== 4'b0000 || busy4 !== 1'b0) begin
         $display("FAIL idle_after_reset: got led=%b busy=%b want led=0000 busy=0", led4, busy4);
         n_err++;
      end
   endtask

   task automatic test_chase_left();
      logic [3:0] exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      pulse_start(2'd0);
      for (int k = 0; k < 5; k++)
         for (int c = 0; c < 4; c++) begin
            n_vec++;
            if (led4 !== exp[k] || busy4 !== 1'b1 || done4 !== (k > 0 && c == 0)) begin
               $display("FAIL chase_left step%0d cyc%0d: got led=%b busy=%b done=%b want led=%b busy=1 done=%b",
                        k, c, led4, busy4, done4, exp[k], k > 0 && c == 0);
               n_err++;
            end
            tick();
         end
      tick();
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (led4 !== 4'b0000 || busy4 !== 1'b0) begin
         $display("FAIL async_reset: got led=%b busy=%b want led=0000 busy=0", led4, busy4);
         n_err++;
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_pingpong();
      logic [3:0] exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
      pulse_start(2'd2);
      for (int k = 0; k < 8; k++)
         for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (led3 !== exp[k] || done3 !== (k > 0 && c == 0)) begin
               $display("FAIL pingpong step%0d cyc%0d: got led=%b done=%b want led=%b done=%b",
                        k, c, led3, done3, exp[k], k > 0 && c == 0);
               n_err++;
            end
            tick();
         end
   endtask

   task automatic test_mode_change();
      logic [3:0] exp [3] = '{4'b1111, 4'b0000, 4'b1111};
      pulse_start(2'd0);
      repeat (8) tick();
      for (int c = 0; c < 4; c++) begin
         n_vec++;
         if (led4 !== 4'b0100 || done4 !== (c == 0)) begin
            $display("FAIL mode_change_hold cyc%0d: got led=%b done=%b want led=0100 done=%b", c, led4, done4, c == 0);
            n_err++;
         end
         if (c == 1) mode_sel = 2'd3;
         tick();
      end
      for (int k = 0; k < 3; k++)
         for (int c = 0; c < 4; c++) begin
            n_vec++;
            if (led4 !== exp[k] || done4 !== (c == 0)) begin
               $display("FAIL mode_change step%0d cyc%0d: got led=%b done=%b want led=%b done=%b",
                        k, c, led4, done4, exp[k], c == 0);
               n_err++;
            end
            tick();
         end
   endtask

   task automatic test_hold();
      pulse_start(2'd0);
      tick();
      tick();
      hold = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_vec++;
         if (led4 !== 4'b0001 || busy4 !== 1'b1 || done4 !== 1'b0) begin
            $display("FAIL hold cyc%0d: got led=%b busy=%b done=%b want led=0001 busy=1 done=0", i, led4, busy4, done4);
            n_err++;
         end
      end
      hold = 1'b0;
      tick();
      n_vec++;
      if (led4 !== 4'b0001 || done4 !== 1'b0) begin
         $display("FAIL hold_release+1: got led=%b done=%b want led=0001 done=0", led4, done4);
         n_err++;
      end
      tick();
      n_vec++;
      if (led4 !== 4'b0010 || done4 !== 1'b1) begin
         $display("FAIL hold_release+2: got led=%b done=%b want led=0010 done=1", led4, done4);
         n_err++;
      end
   endtask

   task automatic test_start_stop();
      start = 1'b1;
      stop = 1'b1;
      tick();
      start = 1'b0;
      stop = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_vec++;
         if (led4 !== 4'b0000 || busy4 !== 1'b0 || done4 !== 1'b0) begin
            $display("FAIL start_stop cyc%0d: got led=%b busy=%b done=%b want led=0000 busy=0 done=0", i, led4, busy4, done4);
            n_err++;
         end
         tick();
      end
      pulse_start(2'd1);
      for (int c = 0; c < 4; c++) begin
         n_vec++;
         if (led4 !== 4'b1000 || busy4 !== 1'b1 || done4 !== 1'b0) begin
            $display("FAIL restart_idle cyc%0d: got led=%b busy=%b done=%b want led=1000 busy=1 done=0", c, led4, busy4, done4);
            n_err++;
         end
         tick();
      end
      n_vec++;
      if (led4 !== 4'b0100 || done4 !== 1'b1) begin
         $display("FAIL restart_idle_step: got led=%b done=%b want led=0100 done=1", led4, done4);
         n_err++;
      end
   endtask

   task automatic test_back_to_back();
      repeat (4) tick();
      n_vec++;
      if (led4 !== 4'b0010) begin
         $display("FAIL restart_setup: got led=%b want led=0010", led4);
         n_err++;
      end
      tick();
      pulse_start(2'd0);
      for (int c = 0; c < 4; c++) begin
         n_vec++;
         if (led4 !== 4'b0001 || done4 !== 1'b0) begin
            $display("FAIL restart_run cyc%0d: got led=%b done=%b want led=0001 done=0", c, led4, done4);
            n_err++;
         end
         tick();
      end
      n_vec++;
      if (led4 !== 4'b0010 || done4 !== 1'b1) begin
         $display("FAIL restart_run_step: got led=%b done=%b want led=0010 done=1", led4, done4);
         n_err++;
      end
      repeat (3) tick();
      hold = 1'b1;
      tick();
      n_vec++;
      if (led4 !== 4'b0010 || done4 !== 1'b0 || busy4 !== 1'b1) begin
         $display("FAIL hold_boundary: got led=%b busy=%b done=%b want led=0010 busy=1 done=0", led4, busy4, done4);
         n_err++;
      end
      hold = 1'b0;
      tick();
      n_vec++;
      if (led4 !== 4'b0100 || done4 !== 1'b1) begin
         $display("FAIL hold_boundary_release: got led=%b done=%b want led=0100 done=1", led4, done4);
         n_err++;
      end
   endtask

   initial begin
      test_reset();
      test_chase_left();
      test_pingpong();
      test_mode_change();
      test_hold();
      test_start_stop();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
